mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multicycle sequencer for the 32-bit MIPS datapath. Splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps and drives the datapath control signals (reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg, ALU_Control, branch, jump). Also drives the IR/PC write strobes and a data-memory ready handshake. Sits between the instruction/data memories and the datapath and replaces the single-cycle combinational control. Also provides retired-instruction count, run gating, and error halting.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)
MEM_TIMEOUT, 15, max cycles in MEM waiting for mem_ready before error halt (1..255)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
run  input  1  permits leaving FETCH; sampled only in FETCH
opcode  input  6  instr[31:26] from datapath
funct  input  6  instr[5:0] from datapath
mem_ready  input  1  data memory done; sampled in MEM only
ir_write  output  1  latch instruction register (FETCH strobe)
pc_write  output  1  update PC (strobe on final cycle of each instruction)
reg_dst  output  1  write reg select (1 = rd)
reg_write  output  1  register file write strobe
alu_src  output  1  ALU operand B select (1 = immediate)
mem_read  output  1  data memory read enable
mem_write  output  1  data memory write enable
mem_to_reg  output  1  writeback select (1 = memory)
ALU_Control  output  4  ALU operation
branch  output  1  beq qualify
jump  output  1  jump select
state  output  3  current state encoding
instr_count  output  CNT_W  retired instructions
halted  output  1  sticky; FSM in HALT
illegal_op  output  1  sticky; unknown opcode/funct caused halt
mem_timeout  output  1  sticky; MEM wait expired

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- Reset (reset=0, async): state=FETCH. All outputs 0, instr_count=0, sticky flags 0. Deasserting reset mid-instruction restarts at FETCH. No strobe survives reset.
- FETCH: run=1 -> ir_write=1 for that cycle, go DECODE; run=0 -> stay, no strobes.
- DECODE: register decoded class/ALU_Control. These are held stable through the rest of the instruction.
- Decoded classes:
  - R (op 000000), funct: add 100000->0010, sub 100010->0110, and 100100->0000, or 100101->0001, slt 101010->0111, nor 100111->1100.
  - lw 100011, sw 101011, addi 001000 -> ALU 0010.
  - beq 000100 -> ALU 0110.
  - j 000010.
  - Any other opcode, or R with unlisted funct: go HALT, set illegal_op.
- Static levels per class, from DECODE to end of instruction:
  - R: reg_dst=1, alu_src=0, mem_to_reg=0.
  - addi: alu_src=1, reg_dst=0, mem_to_reg=0.
  - lw: alu_src=1, mem_to_reg=1.
  - sw: alu_src=1.
  - beq: branch=1.
  - j: jump=1.
- EXEC:
  - R/addi -> WB.
  - lw/sw -> MEM.
  - beq/j: pc_write=1, retire, -> FETCH. The datapath applies zero&branch.
- MEM:
  - lw holds mem_read=1; sw holds mem_write=1.
  - Wait counter starts at 0 on entry and increments each cycle mem_ready=0.
  - mem_ready=1: lw -> WB; sw -> pc_write=1, retire, -> FETCH. mem_read/mem_write drop on the next cycle.
  - Counter reaching MEM_TIMEOUT with mem_ready=0: -> HALT, set mem_timeout, drop enables. mem_ready arriving on that same cycle wins (no timeout).
- WB: reg_write=1, pc_write=1, retire, -> FETCH.
- Retire: instr_count increments on every pc_write cycle and wraps at all-ones -> 0.
- HALT: all strobes/enables 0, halted=1. Exit only via reset.
- Latency with mem_ready immediate: R/addi 4 cycles, lw 5, sw 4, beq/j 3. Each mem_ready wait cycle adds 1.
- Exactly one pc_write and at most one reg_write per instruction. ir_write only in FETCH.

Test Plan:
- Reset then run=1, opcode=000000 funct=100000 -> ir_write cyc0; cycle 3 (WB) reg_write=1, pc_write=1, reg_dst=1, ALU_Control=0010; instr_count=1.
- lw with mem_ready low 3 cycles then high -> mem_read held 4 cycles in MEM; next cycle WB with mem_to_reg=1, reg_write=1; total 8 cycles.
- sw, mem_ready never asserted, MEM_TIMEOUT=15 -> HALT after 15 MEM cycles; mem_timeout=1, halted=1, mem_write=0, instr_count unchanged.
- beq (000100) then j (000010) -> each 3 cycles, pc_write in EXEC with branch=1 and ALU 0110, then jump=1; reg_write never 1; instr_count +2.
- opcode 111111 -> HALT after DECODE, illegal_op=1; run toggling has no effect; reset=0 clears all flags and state=FETCH.
- CNT_W=2, retire 5 addi -> instr_count sequence 1,2,3,0,1. run=0 in FETCH holds state 0 with no ir_write. Reset pulse in MEM -> mem_read drops immediately.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multicycle sequencer for a 32-bit MIPS datapath. Each instruction is
// stepped through FETCH / DECODE / EXEC / MEM / WB. The block drives the
// datapath control levels, the IR/PC write strobes and the data-memory
// enables. It also keeps a retired-instruction counter, gates the start of
// each instruction with run, and halts on an illegal opcode or a
// data-memory timeout.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   run                   start permission, looked at only in FETCH
//   opcode, funct         instruction fields from the latched IR
//   mem_ready             data-memory completion, looked at only in MEM
//   ir_write, pc_write    IR latch strobe (FETCH) / PC update strobe (last cycle)
//   reg_dst .. jump       datapath control levels and ALU_Control
//   state                 current FSM state (FETCH=0 .. WB=4, HALT=7)
//   instr_count           retired instructions, wraps modulo 2^CNT_W
//   halted, illegal_op,   halt status and sticky cause flags
//   mem_timeout
//
// Handshake: run and mem_ready are level qualifiers with no handshake
// back. run=1 in FETCH starts one instruction. While in MEM, mem_read or
// mem_write stays high until the first cycle that sees mem_ready=1. The
// enable drops on the cycle after mem_ready=1. If mem_ready does not arrive
// within MEM_TIMEOUT cycles, the FSM halts.
module mips_multicycle_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic [3:0]       ALU_Control,
    output logic             branch,
    output logic             jump,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             halted,
    output logic             illegal_op,
    output logic             mem_timeout
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [2:0] {C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_ILL} cls_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d, dec_cls, cur_cls;
    logic [3:0]       alu_q, alu_d, dec_alu, cur_alu;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             illegal_q, illegal_d, timeout_q, timeout_d;

    // Instruction decode from the live IR fields.
    always_comb begin
        dec_cls = C_ILL;
        dec_alu = 4'b0000;
        case (opcode)
            6'b000000: begin
                dec_cls = C_R;
                case (funct)
                    6'b100000: dec_alu = 4'b0010;
                    6'b100010: dec_alu = 4'b0110;
                    6'b100100: dec_alu = 4'b0000;
                    6'b100101: dec_alu = 4'b0001;
                    6'b101010: dec_alu = 4'b0111;
                    6'b100111: dec_alu = 4'b1100;
                    default:   dec_cls = C_ILL;
                endcase
            end
            6'b100011: begin dec_cls = C_LW;   dec_alu = 4'b0010; end
            6'b101011: begin dec_cls = C_SW;   dec_alu = 4'b0010; end
            6'b001000: begin dec_cls = C_ADDI; dec_alu = 4'b0010; end
            6'b000100: begin dec_cls = C_BEQ;  dec_alu = 4'b0110; end
            6'b000010: begin dec_cls = C_J;    dec_alu = 4'b0000; end
            default:   ;
        endcase
    end

    // In DECODE the class is not registered yet, so the live decode drives
    // the levels. From EXEC onward the registered copy drives them. This
    // keeps the levels stable even if the IR fields move.
    assign cur_cls = (state_q == S_DECODE) ? dec_cls : cls_q;
    assign cur_alu = (state_q == S_DECODE) ? dec_alu : alu_q;

    // Next state and strobes.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        alu_d     = alu_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Gate with reset so that no IR strobe leaks out during reset.
                if (run && reset) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                alu_d = dec_alu;
                if (dec_cls == C_ILL) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                wait_d = '0;
                case (cls_q)
                    C_LW, C_SW: state_d = S_MEM;
                    C_BEQ, C_J: begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_read  = (cls_q == C_LW);
                mem_write = (cls_q == C_SW);
                // mem_ready is checked first, so a completion on the last
                // allowed cycle still wins over the timeout.
                if (mem_ready) begin
                    if (cls_q == C_LW) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT:  ;
            default: state_d = S_FETCH;
        endcase
    end

    // Datapath control levels, held from DECODE to the end of the instruction.
    always_comb begin
        reg_dst     = 1'b0;
        alu_src     = 1'b0;
        mem_to_reg  = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        ALU_Control = 4'b0000;
        if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            ALU_Control = cur_alu;
            case (cur_cls)
                C_R:     reg_dst = 1'b1;
                C_ADDI:  alu_src = 1'b1;
                C_LW:    begin alu_src = 1'b1; mem_to_reg = 1'b1; end
                C_SW:    alu_src = 1'b1;
                C_BEQ:   branch = 1'b1;
                C_J:     jump = 1'b1;
                default: ;
            endcase
        end
    end

    // Retire on every PC update. The counter wraps naturally.
    always_comb begin
        instr_count_d = instr_count_q;
        if (pc_write) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_FETCH;
            cls_q         <= C_ILL;
            alu_q         <= 4'b0000;
            wait_q        <= '0;
            instr_count_q <= '0;
            illegal_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cls_q         <= cls_d;
            alu_q         <= alu_d;
            wait_q        <= wait_d;
            instr_count_q <= instr_count_d;
            illegal_q     <= illegal_d;
            timeout_q     <= timeout_d;
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;
    assign halted      = (state_q == S_HALT);
    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
// Drives directed and random instruction streams into mips_multicycle_ctrl.
// Each cycle is compared with a reference model. The model describes every
// instruction as a sequence of phases built from its class. It also tracks
// the retired count and the sticky flags separately.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W       = 2;
    localparam int MEM_TIMEOUT = 15;

    localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_HALT = 7;
    localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             ir_write, pc_write, reg_dst, reg_write, alu_src;
    logic             mem_read, mem_write, mem_to_reg, branch, jump;
    logic [3:0]       ALU_Control;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;
    logic             halted, illegal_op, mem_timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_count = 0;
    bit exp_ill   = 1'b0;
    bit exp_to    = 1'b0;

    logic [5:0] r_functs [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    logic [5:0] i_ops    [5] = '{6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};

    mips_multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ALU_Control(ALU_Control), .branch(branch), .jump(jump), .state(state),
        .instr_count(instr_count), .halted(halted), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: the instruction class table.
    function automatic int ref_kind(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'b000000: return (fn inside {6'b100000, 6'b100010, 6'b100100,
                                          6'b100101, 6'b101010, 6'b100111}) ? K_R : K_ILL;
            6'b001000: return K_ADDI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu(int kind, logic [5:0] fn);
        if (kind == K_R) begin
            case (fn)
                6'b100000: return 4'b0010;
                6'b100010: return 4'b0110;
                6'b100100: return 4'b0000;
                6'b100101: return 4'b0001;
                6'b101010: return 4'b0111;
                default:   return 4'b1100;
            endcase
        end
        if (kind inside {K_ADDI, K_LW, K_SW}) return 4'b0010;
        if (kind == K_BEQ) return 4'b0110;
        return 4'b0000;
    endfunction

    // Expected control bits, as {ir_write, pc_write, reg_write, reg_dst,
    // alu_src, mem_read, mem_write, mem_to_reg, branch, jump, halted,
    // illegal_op, mem_timeout}.
    function automatic logic [12:0] exp_ctl(int ph, int kind, bit run_v, bit rdy_v);
        bit irw = 0, pcw = 0, rw = 0, rd = 0, as = 0, mr = 0, mw = 0;
        bit m2r = 0, br = 0, jp = 0, hl = 0;
        if (ph inside {P_DECODE, P_EXEC, P_MEM, P_WB}) begin
            rd  = (kind == K_R);
            as  = (kind inside {K_ADDI, K_LW, K_SW});
            m2r = (kind == K_LW);
            br  = (kind == K_BEQ);
            jp  = (kind == K_J);
        end
        case (ph)
            P_FETCH: irw = run_v;
            P_EXEC:  pcw = (kind inside {K_BEQ, K_J});
            P_MEM: begin
                mr  = (kind == K_LW);
                mw  = (kind == K_SW);
                pcw = (kind == K_SW) && rdy_v;
            end
            P_WB: begin rw = 1; pcw = 1; end
            P_HALT: hl = 1;
            default: ;
        endcase
        return {irw, pcw, rw, rd, as, mr, mw, m2r, br, jp, hl, exp_ill, exp_to};
    endfunction

    // One clock cycle: drive at the falling edge, compare 1 ns later.
    task automatic step(int ph, int kind, bit run_v, bit rdy_v);
        logic [12:0] e;
        bit active;
        @(negedge clk);
        run = run_v;
        mem_ready = rdy_v;
        #1;
        e = exp_ctl(ph, kind, run_v, rdy_v);
        active = (ph inside {P_DECODE, P_EXEC, P_MEM, P_WB});
        check("state", {29'd0, state}, ph);
        check("ctl", {19'd0, ir_write, pc_write, reg_write, reg_dst, alu_src, mem_read,
                      mem_write, mem_to_reg, branch, jump, halted, illegal_op, mem_timeout}, e);
        if (!(active && kind == K_J)) begin
            check("alu", {28'd0, ALU_Control}, active ? ref_alu(kind, funct) : 4'd0);
        end
        check("count", {{(32-CNT_W){1'b0}}, instr_count}, exp_count);
        if (e[11]) exp_count = (exp_count + 1) % (1 << CNT_W);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        run = 1'($urandom);
        mem_ready = 1'($urandom);
        #1;
        exp_count = 0;
        exp_ill = 1'b0;
        exp_to = 1'b0;
        check("rst_state", {29'd0, state}, P_FETCH);
        check("rst_ctl", {19'd0, ir_write, pc_write, reg_write, reg_dst, alu_src, mem_read,
                          mem_write, mem_to_reg, branch, jump, halted, illegal_op, mem_timeout}, 0);
        check("rst_count", {{(32-CNT_W){1'b0}}, instr_count}, 0);
        @(negedge clk);
        run = 1'b0;
        reset = 1'b1;
    endtask

    task automatic halt_cycles();
        for (int i = 0; i < 4; i++) step(P_HALT, K_ILL, 1'($urandom), 1'($urandom));
        do_reset();
    endtask

    task automatic do_instr(logic [5:0] op, logic [5:0] fn, int idle, int waits);
        int kind;
        bit rdy;
        kind = ref_kind(op, fn);
        for (int i = 0; i < idle; i++) step(P_FETCH, kind, 1'b0, 1'($urandom));
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        step(P_FETCH, kind, 1'b1, 1'($urandom));
        opcode = op;
        funct  = fn;
        step(P_DECODE, kind, 1'($urandom), 1'($urandom));
        if (kind == K_ILL) begin
            exp_ill = 1'b1;
            halt_cycles();
            return;
        end
        step(P_EXEC, kind, 1'($urandom), 1'($urandom));
        if (kind inside {K_BEQ, K_J}) return;
        if (kind inside {K_LW, K_SW}) begin
            for (int i = 0; i < MEM_TIMEOUT; i++) begin
                rdy = (i == waits);
                step(P_MEM, kind, 1'($urandom), rdy);
                if (rdy) break;
            end
            if (waits >= MEM_TIMEOUT) begin
                exp_to = 1'b1;
                halt_cycles();
                return;
            end
            if (kind == K_SW) return;
        end
        step(P_WB, kind, 1'($urandom), 1'($urandom));
    endtask

    initial begin
        int sel;
        int w;
        logic [5:0] op;
        logic [5:0] fn;
        reset = 1'b0;
        run = 1'b0;
        mem_ready = 1'b0;
        opcode = 6'd0;
        funct = 6'd0;
        do_reset();

        // Directed cases.
        do_instr(6'b000000, 6'b100000, 0, 0);         // add
        do_instr(6'b100011, 6'($urandom), 1, 3);      // lw, three wait cycles
        do_instr(6'b000100, 6'($urandom), 0, 0);      // beq
        do_instr(6'b000010, 6'($urandom), 2, 0);      // j
        do_instr(6'b101011, 6'($urandom), 0, 100);    // sw, mem_ready never comes
        do_instr(6'b111111, 6'($urandom), 0, 0);      // illegal opcode
        for (int i = 0; i < 5; i++) do_instr(6'b001000, 6'($urandom), 0, 0); // count wraps
        do_instr(6'b100011, 6'($urandom), 0, MEM_TIMEOUT - 1); // ready on last allowed cycle
        do_instr(6'b000000, 6'b000000, 0, 0);         // R with an unknown funct

        // An async reset while in MEM drops mem_read at once.
        opcode = 6'b100011;
        funct = 6'($urandom);
        step(P_FETCH, K_LW, 1'b1, 1'b0);
        step(P_DECODE, K_LW, 1'b0, 1'b0);
        step(P_EXEC, K_LW, 1'b0, 1'b1);
        step(P_MEM, K_LW, 1'b0, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_mem_read", {31'd0, mem_read}, 0);
        check("rst_mid_state", {29'd0, state}, P_FETCH);
        exp_count = 0;
        exp_ill = 1'b0;
        exp_to = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_instr(6'b000000, 6'b100101, 0, 0);

        // Random instruction stream.
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 19);
            fn = 6'($urandom);
            if (sel < 8) begin
                op = 6'b000000;
                fn = r_functs[$urandom_range(0, 5)];
            end else if (sel < 18) begin
                op = i_ops[$urandom_range(0, 4)];
            end else if (sel == 18) begin
                op = 6'($urandom);
            end else begin
                op = 6'b000000;
            end
            w = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) w = $urandom_range(MEM_TIMEOUT - 2, MEM_TIMEOUT + 2);
            do_instr(op, fn, $urandom_range(0, 2), w);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
